pipe_ctrl: RTL

Central pipeline controller for the 5-stage core. It generates the 6-bit stall vector and the flush signals consumed by every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It sequences branch-mispredict and trap redirects around outstanding bus transactions, which cannot be aborted. It also keeps a stall-cycle performance counter and a bus-wait watchdog.

---
 rtl/pipe_ctrl_if.sv | 40 ++++
 rtl/pipe_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: hazard requests and redirect targets in,
// stall vector, flushes, redirect and status out.
interface pipe_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
);
  logic              if_req;
  logic              if_busy;
  logic              id_req;
  logic              ex_req;
  logic              mem_req;
  logic              mem_busy;
  logic              br_req;
  logic [ADDR_W-1:0] br_pc;
  logic              trap_req;
  logic [ADDR_W-1:0] trap_pc;
  logic [5:0]        stall;
  logic              flush;
  logic              flush_fe;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  stall_cnt;
  logic              timeout;

  // Pipeline side: raises requests, consumes stall/flush/redirect
  modport master (
    output if_req, if_busy, id_req, ex_req, mem_req, mem_busy,
           br_req, br_pc, trap_req, trap_pc,
    input  stall, flush, flush_fe, redirect_valid, redirect_pc,
           stall_cnt, timeout
  );

  // Controller side
  modport slave (
    input  if_req, if_busy, id_req, ex_req, mem_req, mem_busy,
           br_req, br_pc, trap_req, trap_pc,
    output stall, flush, flush_fe, redirect_valid, redirect_pc,
           stall_cnt, timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall vector, flushes and PC redirects for the
// 5-stage core. Redirects wait for outstanding bus transactions to finish
// (they cannot be aborted); a watchdog bounds that wait.
module pipe_ctrl #(
  parameter int ADDR_W   = 64,
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 256
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam int WAIT_W = $clog2(WAIT_MAX) + 1;

  typedef enum logic [1:0] {RUN, BR_WAIT, WAIT_BUS, FLUSH} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc_q, pc_nxt;
  logic [WAIT_W-1:0]   wait_q, wait_nxt;
  logic [CNT_W-1:0]    cnt_q;

  logic [5:0]          stall_c;
  logic                flush_c, flush_fe_c, rv_c, timeout_c;
  logic [ADDR_W-1:0]   rpc_c;

  // Stall everything up to and including the highest requesting stage
  function automatic logic [5:0] req_mask(input logic i, input logic d,
                                          input logic e, input logic m);
    if (m)      return 6'b011111;
    else if (e) return 6'b001111;
    else if (d) return 6'b000111;
    else if (i) return 6'b000011;
    else        return 6'b000000;
  endfunction

  // Next-state and output decode
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc_q;
    wait_nxt   = wait_q;
    stall_c    = 6'b000000;
    flush_c    = 1'b0;
    flush_fe_c = 1'b0;
    rv_c       = 1'b0;
    rpc_c      = '0;
    timeout_c  = 1'b0;
    case (state)
      RUN, BR_WAIT: begin
        if (bus.trap_req) begin
          // Trap wins over any branch, pending or new
          stall_c   = 6'b011111;
          pc_nxt    = bus.trap_pc;
          state_nxt = (bus.mem_busy || bus.if_busy) ? WAIT_BUS : FLUSH;
        end else if (state == RUN) begin
          if (bus.br_req && !bus.ex_req && !bus.mem_req) begin
            flush_fe_c = 1'b1;
            if (!bus.if_busy) begin
              rv_c  = 1'b1;
              rpc_c = bus.br_pc;
            end else begin
              pc_nxt    = bus.br_pc;
              state_nxt = BR_WAIT;
            end
          end else begin
            stall_c = req_mask(bus.if_req, bus.id_req, bus.ex_req, bus.mem_req);
          end
        end else begin
          // Hold the front end until the fetch completes and EX/MEM are free
          if (!bus.if_busy && !bus.ex_req && !bus.mem_req) begin
            rv_c      = 1'b1;
            rpc_c     = pc_q;
            state_nxt = RUN;
          end else begin
            stall_c = 6'b000011 | req_mask(1'b0, 1'b0, bus.ex_req, bus.mem_req);
          end
        end
      end
      WAIT_BUS: begin
        stall_c  = 6'b011111;
        wait_nxt = wait_q + 1'b1;
        if (wait_q == WAIT_W'(WAIT_MAX - 1)) begin
          timeout_c = 1'b1;
          state_nxt = FLUSH;
        end else if (!bus.mem_busy && !bus.if_busy) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        flush_c    = 1'b1;
        flush_fe_c = 1'b1;
        rv_c       = 1'b1;
        rpc_c      = pc_q;
        wait_nxt   = '0;
        state_nxt  = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // State, latched target, wait counter and stall-cycle counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= RUN;
      pc_q   <= '0;
      wait_q <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      pc_q   <= pc_nxt;
      wait_q <= wait_nxt;
      cnt_q  <= cnt_q + CNT_W'(stall_c[0]);
    end
  end

  // Everything reads as zero while reset is held
  assign bus.stall          = rst ? stall_c    : 6'b000000;
  assign bus.flush          = rst & flush_c;
  assign bus.flush_fe       = rst & flush_fe_c;
  assign bus.redirect_valid = rst & rv_c;
  assign bus.redirect_pc    = rst ? rpc_c      : '0;
  assign bus.timeout        = rst & timeout_c;
  assign bus.stall_cnt      = rst ? cnt_q      : '0;

endmodule
